// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared definitions for the interrupt controller: APB register offsets
// (decoded from PADDR[3:2]), ID register layout and synchroniser depth.
//
// Configuration macro: IRQ_CTRL_SYNC_EN -- when defined, each source passes
// through a two-flop synchroniser before edge detection (SYNC_STAGES = 2).
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 5;

  // Register offsets, as word index PADDR[3:2].
  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_MASK    = 2'd1,
    REG_ID      = 2'd2,
    REG_SWSET   = 2'd3
  } reg_sel_e;

  // Bit of the ID register that mirrors irq_o.
  localparam int ID_VALID_BIT = 31;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  // ID register image: valid flag at ID_VALID_BIT, index in the low bits.
  function automatic logic [DATA_W-1:0] id_word(logic valid, logic [IDX_W-1:0] id);
    logic [DATA_W-1:0] w;
    w               = '0;
    w[ID_VALID_BIT] = valid;
    w[IDX_W-1:0]    = id;
    return w;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_ctrl_if
// APB slave bus bundle for the interrupt controller.
//   master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, receives
//                   PRDATA/PREADY (testbench or interconnect side).
//   slave  modport: the opposite directions (irq_ctrl side).
// -----------------------------------------------------------------------------
interface irq_ctrl_if;
  import irq_ctrl_pkg::*;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index-first priority encoder: index 0 has the highest priority.
//   req_i   [NSRC-1:0]  request vector
//   idx_o   [4:0]       lowest set index, 0 when no request
//   valid_o             at least one request set
// -----------------------------------------------------------------------------
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0]  req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // NOTE: every output gets a default before any conditional assignment, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
// Edge-sensitive interrupt controller with an APB register interface.
//
// Ports:
//   PCLK        clock, all state changes on the rising edge
//   PRESET      asynchronous, active-high reset
//   irq_src_i   [NSRC-1:0] interrupt sources, rising-edge sensitive
//   apb         irq_ctrl_if.slave APB bus (zero wait states)
//   irq_o       core interrupt request (|(pending & mask))
//   irq_id_o    [4:0] lowest active index
//   irq_ack_i   core acknowledge of irq_id_o; ignored while irq_o = 0
//
// Register map (PADDR[3:2]): 0 PENDING (R/W1C), 1 MASK (R/W),
//   2 ID (RO, {irq_o @31, irq_id_o @4:0}), 3 SWSET (W1S, reads 0).
//
// Configuration macro: IRQ_CTRL_SYNC_EN adds a two-flop synchroniser per
// source ahead of edge detection (+2 cycles of set latency).
// -----------------------------------------------------------------------------
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [NSRC-1:0]  irq_src_i,
  irq_ctrl_if.slave        apb,
  output logic             irq_o,
  output logic [IDX_W-1:0] irq_id_o,
  input  logic             irq_ack_i
);

  // Edge detection is held off for this many edges after reset so that a
  // source already high when reset releases is not seen as a new edge.
  localparam int ARM_LEN = SYNC_STAGES + 1;

  logic [NSRC-1:0]    src_in;
  logic [NSRC-1:0]    src_q;
  logic [NSRC-1:0]    rise;
  logic [NSRC-1:0]    pending;
  logic [NSRC-1:0]    mask;
  logic [NSRC-1:0]    active;
  logic [NSRC-1:0]    ack_mask;
  logic [NSRC-1:0]    w1c_mask;
  logic [NSRC-1:0]    swset_mask;
  logic [ARM_LEN-1:0] arm_q;
  logic               armed;
  logic               mask_we;
  logic               wr_en;
  logic               rd_en;
  logic               ack_take;
  logic               enc_valid;
  reg_sel_e           sel;
  logic [DATA_W-1:0]  rdata;
  logic               unused_ok;

  // ---------------------------------------------------------------------------
  // Source conditioning
  // ---------------------------------------------------------------------------
`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync_q1;
  logic [NSRC-1:0] sync_q2;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign src_in = sync_q2;
`else
  assign src_in = irq_src_i;
`endif

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours. Every flop here
  // is a control register and gets an explicit reset value.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      src_q <= '0;
      arm_q <= '0;
    end else begin
      src_q <= src_in;
      arm_q <= (arm_q << 1) | ARM_LEN'(1);
    end
  end

  assign armed = arm_q[ARM_LEN-1];
  assign rise  = src_in & ~src_q & {NSRC{armed}};

  // ---------------------------------------------------------------------------
  // Priority / request
  // ---------------------------------------------------------------------------
  assign active = pending & mask;

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio_enc (
    .req_i   (active),
    .idx_o   (irq_id_o),
    .valid_o (enc_valid)
  );

  assign irq_o    = enc_valid;
  assign ack_take = irq_ack_i & irq_o;

  always_comb begin
    ack_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      ack_mask[i] = ack_take && (irq_id_o == IDX_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  assign sel   = reg_sel_e'(apb.PADDR[3:2]);
  assign wr_en = apb.PSEL & apb.PENABLE &  apb.PWRITE;
  assign rd_en = apb.PSEL & apb.PENABLE & ~apb.PWRITE;

  always_comb begin
    w1c_mask   = '0;
    swset_mask = '0;
    mask_we    = 1'b0;
    if (wr_en) begin
      case (sel)
        REG_PENDING: w1c_mask   = apb.PWDATA[NSRC-1:0];
        REG_MASK:    mask_we    = 1'b1;
        REG_SWSET:   swset_mask = apb.PWDATA[NSRC-1:0];
        default:     ; // ID is read-only
      endcase
    end
  end

  // Set events (edge or SWSET) are OR-ed in after the clears, so a set wins
  // over an ack or W1C to the same bit in the same cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~(ack_mask | w1c_mask)) | rise | swset_mask;
      if (mask_we) begin
        mask <= apb.PWDATA[NSRC-1:0];
      end
    end
  end

  // Read data is driven only during a read access phase and forced to zero
  // during reset; bits at or above NSRC stay zero.
  always_comb begin
    rdata = '0;
    if (rd_en && !PRESET) begin
      case (sel)
        REG_PENDING: rdata[NSRC-1:0] = pending;
        REG_MASK:    rdata[NSRC-1:0] = mask;
        REG_ID:      rdata           = id_word(irq_o, irq_id_o);
        default:     rdata           = '0;
      endcase
    end
  end

  assign apb.PRDATA = rdata;
  assign apb.PREADY = apb.PSEL & apb.PENABLE & ~PRESET;

  // Address and data bits outside the decoded fields are intentionally ignored.
  assign unused_ok = &{1'b0, apb.PADDR[ADDR_W-1:4], apb.PADDR[1:0], apb.PWDATA};

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
// Self-checking bench for irq_ctrl (NSRC = 8). Expected values are pushed to
// a scoreboard queue when stimulus is applied and popped when the matching
// DUT output is sampled. Honours IRQ_CTRL_SYNC_EN through SYNC_STAGES.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NSRC = 8;
  localparam int LAT  = SYNC_STAGES;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic [NSRC-1:0]  irq_src;
  logic             irq_o;
  logic [IDX_W-1:0] irq_id;
  logic             irq_ack;

  irq_ctrl_if apb ();

  irq_ctrl #(
    .NSRC (NSRC)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .irq_src_i (irq_src),
    .apb       (apb),
    .irq_o     (irq_o),
    .irq_id_o  (irq_id),
    .irq_ack_i (irq_ack)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "sb_empty";
      e.val = ~got;
    end else begin
      e = sb.pop_front();
    end
    check(e.tag, got, e.val);
  endtask

  function automatic logic [31:0] stat(input logic irq, input logic [4:0] id);
    return {26'd0, irq, id};
  endfunction

  task automatic exp_irq(input string tag, input logic irq, input logic [4:0] id);
    sb_push(tag, stat(irq, id));
    sb_pop(stat(irq_o, irq_id));
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_idle();
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
  endtask

  task automatic apb_write(input reg_sel_e r, input logic [31:0] d);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b1;
    apb.PADDR   = {28'd0, r, 2'b00};
    apb.PWDATA  = d;
    tick();
    apb.PENABLE = 1'b1;
    sb_push("wr_pready", 32'd1);
    sb_push("wr_prdata", 32'd0);
    #1;
    sb_pop({31'd0, apb.PREADY});
    sb_pop(apb.PRDATA);
    tick();
    apb_idle();
  endtask

  task automatic apb_read(input string tag, input reg_sel_e r, input logic [31:0] exp);
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = {28'd0, r, 2'b00};
    sb_push("rd_setup_prdata", 32'd0);
    sb_push(tag, exp);
    #1;
    sb_pop(apb.PRDATA);
    tick();
    apb.PENABLE = 1'b1;
    #1;
    sb_pop(apb.PRDATA);
    tick();
    apb_idle();
  endtask

  task automatic pulse(input logic [NSRC-1:0] bits);
    irq_src = irq_src | bits;
    tick();
    irq_src = irq_src & ~bits;
    repeat (LAT) tick();
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    PRESET      = 1'b1;
    irq_src     = '0;
    irq_ack     = 1'b0;
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b1;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    #12;
    sb_push("rst_pready", 32'd0);
    sb_push("rst_prdata", 32'd0);
    sb_pop({31'd0, apb.PREADY});
    sb_pop(apb.PRDATA);
    exp_irq("rst_irq", 1'b0, 5'd0);
    apb_idle();
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    repeat (ARM_WAIT()) tick();

    // ---------------- single source, ack ----------------
    apb_write(REG_MASK, 32'h01);
    irq_src[0] = 1'b1;
    #1;
    exp_irq("t1_before_edge", 1'b0, 5'd0);
    tick();
    irq_src[0] = 1'b0;
    repeat (LAT) tick();
    exp_irq("t1_set", 1'b1, 5'd0);
    apb_read("t1_pending", REG_PENDING, 32'h01);
    ack();
    exp_irq("t1_acked", 1'b0, 5'd0);
    apb_read("t1_pending_clr", REG_PENDING, 32'h00);

    // ---------------- priority ----------------
    apb_write(REG_MASK, 32'hFF);
    pulse(8'h24);
    exp_irq("t2_id2", 1'b1, 5'd2);
    ack();
    exp_irq("t2_id5", 1'b1, 5'd5);
    ack();
    exp_irq("t2_empty", 1'b0, 5'd0);

    // ---------------- masked pending, ID register ----------------
    apb_write(REG_MASK, 32'h00);
    pulse(8'h08);
    apb_read("t3_pending", REG_PENDING, 32'h08);
    exp_irq("t3_masked", 1'b0, 5'd0);
    apb_write(REG_MASK, 32'h08);
    exp_irq("t3_unmasked", 1'b1, 5'd3);
    apb_read("t3_id", REG_ID, 32'h8000_0003);
    apb_write(REG_ID, 32'hFFFF_FFFF);
    apb_read("t3_id_ro", REG_PENDING, 32'h08);
    apb_write(REG_PENDING, 32'h08);
    apb_read("t3_w1c", REG_PENDING, 32'h00);

    // ---------------- ack with irq_o low is ignored ----------------
    apb_write(REG_MASK, 32'h00);
    pulse(8'h40);
    exp_irq("ack_ign_pre", 1'b0, 5'd0);
    ack();
    apb_read("ack_ignored", REG_PENDING, 32'h40);
    apb_write(REG_PENDING, 32'h40);

    // ---------------- held source, W1C mid-hold ----------------
    apb_write(REG_MASK, 32'h02);
    irq_src[1] = 1'b1;
    repeat (1 + LAT) tick();
    exp_irq("t4_set", 1'b1, 5'd1);
    repeat (2) tick();
    apb_write(REG_PENDING, 32'h02);
    exp_irq("t4_cleared", 1'b0, 5'd0);
    repeat (5) tick();
    exp_irq("t4_stays_clr", 1'b0, 5'd0);
    irq_src[1] = 1'b0;
    tick();
    apb_read("t4_pending", REG_PENDING, 32'h00);

    // ---------------- set wins over same-cycle ack ----------------
    apb_write(REG_MASK, 32'h10);
    pulse(8'h10);
    exp_irq("t5_pre", 1'b1, 5'd4);
    tick();
    irq_src[4] = 1'b1;
    repeat (LAT) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_src[4] = 1'b0;
    exp_irq("t5_set_wins", 1'b1, 5'd4);
    apb_read("t5_pending", REG_PENDING, 32'h10);
    ack();
    exp_irq("t5_cleared", 1'b0, 5'd0);

    // ---------------- SWSET, unimplemented bits ----------------
    apb_write(REG_MASK, 32'hFFFF_FFFF);
    apb_read("mask_width", REG_MASK, 32'h0000_00FF);
    apb_write(REG_SWSET, 32'hFFFF_FF81);
    exp_irq("swset", 1'b1, 5'd0);
    apb_read("swset_pending", REG_PENDING, 32'h81);
    apb_read("swset_reads0", REG_SWSET, 32'h0);
    apb_write(REG_PENDING, 32'hFF);

    // ---------------- reset mid-operation ----------------
    apb_write(REG_SWSET, 32'hA5);
    apb_read("t6_pending", REG_PENDING, 32'hA5);
    exp_irq("t6_pre", 1'b1, 5'd0);
    irq_src[7]  = 1'b1;
    apb.PSEL    = 1'b1;
    apb.PENABLE = 1'b1;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    #2;
    PRESET = 1'b1;
    #1;
    sb_push("t6_rst_pready", 32'd0);
    sb_push("t6_rst_prdata", 32'd0);
    sb_pop({31'd0, apb.PREADY});
    sb_pop(apb.PRDATA);
    exp_irq("t6_rst_irq", 1'b0, 5'd0);
    apb_idle();
    repeat (2) tick();
    PRESET = 1'b0;
    repeat (4 + LAT) tick();
    apb_read("t6_held_src", REG_PENDING, 32'h00);
    apb_read("t6_mask_rst", REG_MASK, 32'h00);
    irq_src[7] = 1'b0;
    repeat (2 + LAT) tick();

    // ---------------- set latency after reset ----------------
    apb_write(REG_MASK, 32'h01);
    irq_src[0] = 1'b1;
    #1;
    exp_irq("lat_0", 1'b0, 5'd0);
    for (int k = 0; k < LAT; k++) begin
      tick();
      exp_irq("lat_wait", 1'b0, 5'd0);
    end
    tick();
    exp_irq("lat_set", 1'b1, 5'd0);
    irq_src[0] = 1'b0;

    check("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Edges to let pass after reset release before sources are exercised.
  function automatic int ARM_WAIT();
    return 2 + LAT;
  endfunction

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 8, number of interrupt sources (range 1..32).
REQ-002 SHALL have port PCLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port PRESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port irq_src_i  input  NSRC  interrupt sources (e.g. timer irq_o), rising-edge sensitive.
REQ-005 SHALL have port PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-006 SHALL have port PADDR  input  32  APB address; only PADDR[3:2] decoded.
REQ-007 SHALL have port PWDATA  input  32  APB write data.
REQ-008 SHALL have port PRDATA  output  32  APB read data.
REQ-009 SHALL have port PREADY  output  1  APB ready.
REQ-010 SHALL have port irq_o  output  1  core interrupt request.
REQ-011 SHALL have port irq_id_o  output  5  index of the highest-priority active source.
REQ-012 SHALL have port irq_ack_i  input  1  core acknowledge of irq_id_o.

Function
REQ-013 SHALL register irq_src_i into src_q each cycle; rising edge = irq_src_i[i] & ~src_q[i].
REQ-014 SHALL set pending[i] on the clock edge at which a rising edge on source i is detected; pending is visible the cycle after irq_src_i first reads high.
REQ-015 SHALL define active = pending & mask; irq_o = |active, combinational from registers.
REQ-016 SHALL drive irq_id_o = lowest index set in active (index 0 is highest priority), 0 when active is empty.
REQ-017 SHALL clear pending[irq_id_o] on a clock edge where irq_ack_i=1 and irq_o=1; ack with irq_o=0 is ignored.
REQ-018 SHALL, for a given bit, let a set event (rising edge or SWSET) win over a same-cycle clear (ack or W1C).
REQ-019 SHALL drive PREADY = PSEL & PENABLE, with zero wait states.
REQ-020 SHALL decode the register map by PADDR[3:2]: 0 PENDING (read; write-1-to-clear), 1 MASK (read/write), 2 ID (read-only {irq_o at bit 31, irq_id_o at bits 4:0}), 3 SWSET (write-1-to-set pending; reads 0).
REQ-021 SHALL drive PRDATA = 0 unless PSEL & PENABLE & ~PWRITE; unimplemented bits at or above NSRC read 0 and ignore writes.
REQ-022 SHALL ignore writes to ID.

Reset
REQ-023 SHALL asynchronously clear pending, mask and src_q (plus synchroniser flops) while PRESET=1.
REQ-024 SHALL hold irq_o=0, irq_id_o=0, PRDATA=0 and PREADY=0 during reset; sources held high across reset release do not raise pending.

Configuration
REQ-025 SHALL, with IRQ_CTRL_SYNC_EN defined, insert a two-flop synchroniser per source ahead of edge detection, adding exactly 2 cycles to REQ-014 latency.
REQ-026 SHALL, without IRQ_CTRL_SYNC_EN, feed irq_src_i directly to edge detection.

Structure
REQ-027 SHALL place register offsets (PENDING, MASK, ID, SWSET) and the ID valid-bit position in the shared package irq_ctrl_pkg.
REQ-028 SHALL implement the lowest-index-first encoder as sub-module irq_prio_enc (NSRC-bit input; 5-bit index plus valid output).

Verification
REQ-029 SHALL cover: mask=0x01, 1-cycle pulse on src[0] -> pending=0x01 next cycle, irq_o=1, irq_id_o=0; ack -> pending=0x00, irq_o=0 next cycle.
REQ-030 SHALL cover: mask=0xFF, src[5] and src[2] rise together -> irq_id_o=2; ack -> irq_id_o=5; ack -> irq_o=0.
REQ-031 SHALL cover: mask=0x00, src[3] pulse -> PENDING reads 0x08 and irq_o=0; write MASK=0x08 -> irq_o=1, ID reads 0x80000003.
REQ-032 SHALL cover: src[1] held high for 10 cycles -> pending set once; W1C 0x02 in cycle 5 -> stays clear.
REQ-033 SHALL cover: pending[4] set, ack for id 4 in the same cycle as a new rising edge on src[4] -> pending[4] remains 1.
REQ-034 SHALL cover: PRESET asserted mid-operation with pending=0xA5 -> all outputs 0 immediately; with IRQ_CTRL_SYNC_EN, first pending appears 3 cycles after irq_src_i rises.
